// File: rtl/serial_comparator_lr_pkg.sv
// Shared encodings for the MSB-first serial magnitude comparator:
// P/Q state-pair codes, FSM states and the bit-index counter width.
package serial_comparator_lr_pkg;

    localparam logic [1:0] PQ_EQ = 2'b00;
    localparam logic [1:0] PQ_GT = 2'b10;
    localparam logic [1:0] PQ_LT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // A 1-bit operand still needs a 1-bit index register.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_comparator_lr_comparison_cell.sv
// One stage of the left-to-right iterative comparator: folds one bit pair
// into the running P/Q state, with the sign bit's sense inverted when signed.
module comparison_cell
    import serial_comparator_lr_pkg::*;
(
    input  logic [1:0] pq_in,
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       is_msb,
    input  logic       signed_mode,
    output logic [1:0] pq_out
);

    // NOTE: pq_out gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pq_out = pq_in;
        if (pq_in == PQ_EQ && a_bit != b_bit) begin
            if (is_msb && signed_mode)
                pq_out = a_bit ? PQ_LT : PQ_GT;
            else
                pq_out = a_bit ? PQ_GT : PQ_LT;
        end
    end

endmodule

// File: rtl/serial_comparator_lr.sv
// Sequential MSB-first magnitude comparator with optional two's-complement
// mode, early exit on the first differing bit and a start/busy/done handshake.
module serial_comparator_lr
    import serial_comparator_lr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             p,
    output logic             q,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] IDX_MSB = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sgn_reg;
    logic [CW-1:0]    idx;
    logic [1:0]       pq;
    logic [1:0]       pq_next;
    logic             mode_sel;

    assign mode_sel = SIGNED_EN ? signed_mode : 1'b0;
    assign p        = pq[1];
    assign q        = pq[0];

    comparison_cell u_cell (
        .pq_in       (pq),
        .a_bit       (a_reg[idx]),
        .b_bit       (b_reg[idx]),
        .is_msb      (idx == IDX_MSB),
        .signed_mode (sgn_reg),
        .pq_out      (pq_next)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sgn_reg <= 1'b0;
            idx     <= '0;
            pq      <= PQ_EQ;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_gt_b  <= 1'b0;
            a_lt_b  <= 1'b0;
            a_eq_b  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sgn_reg <= mode_sel;
                        idx     <= IDX_MSB;
                        pq      <= PQ_EQ;
                        busy    <= 1'b1;
                        a_gt_b  <= 1'b0;
                        a_lt_b  <= 1'b0;
                        a_eq_b  <= 1'b0;
                        state   <= ST_SCAN;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end

                ST_SCAN: begin
                    pq <= pq_next;
                    // Stop at the first decision or once the LSB has been seen.
                    if (pq_next != PQ_EQ || idx == '0) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        a_gt_b <= (pq_next == PQ_GT);
                        a_lt_b <= (pq_next == PQ_LT);
                        a_eq_b <= (pq_next == PQ_EQ);
                        state  <= ST_DONE;
                    end else begin
                        idx    <= idx - 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    illegal_pq: assert property (@(posedge clk) disable iff (!rst_n) pq != 2'b11);

endmodule

// File: tb/tb_serial_comparator_lr.sv
// Directed bench for serial_comparator_lr: an 8-bit instance checked every
// cycle against a transaction-level model, plus a 1-bit instance swept fully.
module tb_serial_comparator_lr;

    logic clk;
    logic rst_n;

    logic       start, signed_mode;
    logic [7:0] a, b;
    logic       busy, done, p, q, a_gt_b, a_lt_b, a_eq_b;

    logic       start1, signed_mode1;
    logic [0:0] a1, b1;
    logic       busy1, done1, p1, q1, gt1, lt1, eq1;

    int checks = 0;
    int errors = 0;

    serial_comparator_lr #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .p(p), .q(q),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b)
    );

    serial_comparator_lr #(.WIDTH(1), .SIGNED_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .p(p1), .q(q1),
        .a_gt_b(gt1), .a_lt_b(lt1), .a_eq_b(eq1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: numeric comparison plus position of the highest differing bit.
    function automatic void model_cmp(input logic [31:0] av, input logic [31:0] bv,
                                      input logic sm, input int w,
                                      output logic [1:0] pq, output int lat);
        longint va, vb;
        logic [31:0] x;
        va = longint'(av);
        vb = longint'(bv);
        if (sm && av[w-1]) va = va - (longint'(1) << w);
        if (sm && bv[w-1]) vb = vb - (longint'(1) << w);
        pq  = (va > vb) ? 2'b10 : (va < vb) ? 2'b01 : 2'b00;
        x   = av ^ bv;
        lat = w;
        for (int i = 0; i < w; i++)
            if (x[i]) lat = w - i;
    endfunction

    // Cycle-level expectations derived from the transaction model.
    logic       m_active = 1'b0, m_done = 1'b0, m_valid = 1'b0;
    logic [1:0] m_pq = 2'b00, m_res = 2'b00;
    int         m_remain = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_done = 1'b0; m_valid = 1'b0;
            m_pq = 2'b00; m_remain = 0;
        end else if (m_active) begin
            m_done = 1'b0;
            m_remain--;
            if (m_remain == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_valid  = 1'b1;
                m_pq     = m_res;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                model_cmp(32'(a), 32'(b), signed_mode, 8, m_res, m_remain);
                m_active = 1'b1;
                m_valid  = 1'b0;
                m_pq     = 2'b00;
            end
        end
    end

    always @(negedge clk) begin
        check("cycle", {25'd0, busy, done, p, q, a_gt_b, a_lt_b, a_eq_b},
              {25'd0, m_active, m_done, m_pq,
               m_valid && m_pq == 2'b10, m_valid && m_pq == 2'b01, m_valid && m_pq == 2'b00});
    end

    // Called at posedge+1; returns at posedge+1 of the done cycle.
    task automatic run(input string name, input logic [7:0] av, input logic [7:0] bv,
                       input logic sm, input bit hold, input int exp_lat,
                       input logic [2:0] exp_res);
        int lat;
        logic [1:0] mpq;
        int mlat;
        start = 1'b1; a = av; b = bv; signed_mode = sm;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!done && hold) begin
                a = 8'($urandom); b = 8'($urandom); signed_mode = ~signed_mode;
            end
        end while (!done && lat < 40);
        start = 1'b0;
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, {a_gt_b, a_lt_b, a_eq_b}, exp_res);
        check({name, " pq"}, {p, q}, exp_res[2:1]);
        model_cmp(32'(av), 32'(bv), sm, 8, mpq, mlat);
        check({name, " model"}, {mpq, 8'(mlat)}, {exp_res[2:1], 8'(exp_lat)});
    endtask

    logic [2:0] w1_tab [8] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        start = 0; signed_mode = 0; a = 0; b = 0;
        start1 = 0; signed_mode1 = 0; a1 = 0; b1 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a scan.
        start = 1'b1; a = 8'h12; b = 8'h13; signed_mode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset outputs", {busy, done, p, q, a_gt_b, a_lt_b, a_eq_b}, 7'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("idle after reset", {busy, done}, 2'b00);
        end

        run("eq_a5",      8'hA5, 8'hA5, 1'b0, 1'b0, 8, 3'b001); @(posedge clk); #1;
        run("msb_uns",    8'h80, 8'h7F, 1'b0, 1'b0, 1, 3'b100); @(posedge clk); #1;
        run("msb_sgn",    8'h80, 8'h7F, 1'b1, 1'b0, 1, 3'b010); @(posedge clk); #1;
        run("mid_30_20",  8'h30, 8'h20, 1'b0, 1'b0, 4, 3'b100); @(posedge clk); #1;
        run("lsb_12_13",  8'h12, 8'h13, 1'b0, 1'b0, 8, 3'b010); @(posedge clk); #1;
        run("hold_start", 8'h01, 8'h00, 1'b0, 1'b1, 8, 3'b100); @(posedge clk); #1;
        run("sgn_neg",    8'hFE, 8'h03, 1'b1, 1'b0, 1, 3'b010); @(posedge clk); #1;
        run("b2b_first",  8'h30, 8'h20, 1'b0, 1'b0, 4, 3'b100);
        run("b2b_second", 8'hFF, 8'hFE, 1'b0, 1'b0, 8, 3'b100);
        repeat (3) @(posedge clk); #1;
        check("hold after done", {p, q, a_gt_b, busy}, 4'b1010);

        // One-bit instance: every operand/mode combination.
        for (int c = 0; c < 8; c++) begin
            int lat;
            logic [1:0] mpq;
            int mlat;
            a1 = c[2]; b1 = c[1]; signed_mode1 = c[0]; start1 = 1'b1;
            @(posedge clk); #1 start1 = 1'b0;
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!done1 && lat < 10);
            check("w1 latency", lat, 1);
            check("w1 result", {gt1, lt1, eq1}, w1_tab[c]);
            check("w1 pq", {p1, q1}, {w1_tab[c][2], w1_tab[c][1]});
            model_cmp(32'(a1), 32'(b1), signed_mode1, 1, mpq, mlat);
            check("w1 model", {mpq, 8'(mlat)}, {w1_tab[c][2:1], 8'd1});
            @(posedge clk); #1;
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_comparator_lr.md
Name: serial_comparator_lr

Overview:
Sequential, parametrised magnitude comparator that scans operand words A and B one bit per clock, left to right (MSB first). It carries the iterative-network state pair P/Q in registers. Unlike the fixed iterative array, it adds:
- a configurable width;
- optional two's-complement (signed) mode;
- early termination at the first differing bit;
- a start/busy/done handshake.
It sits between the operand registers and any control logic that needs an ordered comparison result.

Parameters:
WIDTH, 8, operand width in bits; legal range 1..32.
SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored (always unsigned).

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a comparison; sampled only in IDLE or DONE.
signed_mode  input  1  1 = compare as two's complement; sampled with start.
a  input  WIDTH  operand A; captured when start is accepted.
b  input  WIDTH  operand B; captured when start is accepted.
busy  output  1  high while scanning.
done  output  1  one-cycle pulse when the result becomes valid.
p  output  1  state bit P: 1 = A>B.
q  output  1  state bit Q: 1 = A<B.
a_gt_b  output  1  decoded result; valid from the done cycle until the next accepted start.
a_lt_b  output  1  decoded result; same validity as a_gt_b.
a_eq_b  output  1  decoded result; same validity as a_gt_b.

Behaviour:
- Reset (rst_n low, any time, including mid-scan): state goes to IDLE immediately. busy=0, done=0, p=q=0, a_gt_b=a_lt_b=a_eq_b=0, bit counter=0, operand registers=0.
- P/Q encoding: 00 = equal so far, 10 = A>B, 01 = A<B. Code 11 is illegal and never produced.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 captures a, b and signed_mode, clears P/Q to 00, sets index=WIDTH-1, and moves to SCAN. Decoded outputs clear on acceptance.
- SCAN (busy=1): each cycle evaluates bit[index] of both operands through the comparison cell, and P/Q take the cell output.
  - At the MSB in signed mode, the sense inverts: a_bit=1, b_bit=0 gives 01 (A negative).
  - A decision (P/Q≠00) or index==0 moves to DONE; otherwise index decrements.
- Latency: cycles from the accepting edge to done high equal the number of bits examined. First difference at bit k gives WIDTH-k cycles; equal operands give WIDTH cycles. Minimum 1, maximum WIDTH.
- DONE: done=1 for exactly one cycle, busy=0. Decoded outputs are registered from P/Q (a_eq_b = ~p & ~q). Next state is IDLE, unless start=1 in this cycle, which is accepted as a new request (back-to-back operation).
- start asserted during SCAN is ignored, and operand changes during SCAN have no effect.
- Results, including p/q, hold until the next accepted start or reset.
- WIDTH=1: the single bit is the MSB, and the signed rule applies.

Decomposition:
- Shared package/header holds:
  - P/Q encoding constants PQ_EQ=2'b00, PQ_GT=2'b10, PQ_LT=2'b01;
  - state encodings ST_IDLE, ST_SCAN, ST_DONE;
  - a clog2-based counter width derived from WIDTH.
- One combinational sub-module, comparison_cell: inputs pq_in[1:0], a_bit, b_bit, is_msb, signed_mode; output pq_out[1:0].
  - It passes pq_in through when pq_in≠00.
  - The top level owns the FSM, counter, operand registers and handshake.

Test Plan:
1. Reset: with WIDTH=8, assert rst_n=0 mid-scan (3 cycles after start, A=0x12, B=0x13) -> immediately busy=0, done=0, p=q=0, all decoded outputs 0. After release, the block idles until start.
2. Unsigned equal: A=0xA5, B=0xA5, signed_mode=0 -> done exactly 8 cycles after accept, a_eq_b=1, p=q=0.
3. Early exit at MSB: A=0x80, B=0x7F, unsigned -> done 1 cycle after accept, a_gt_b=1, PQ=10. Same operands with signed_mode=1 -> done 1 cycle after accept, a_lt_b=1, PQ=01.
4. Mid-word decision: A=0x30, B=0x20 -> done 4 cycles after accept, a_gt_b=1. A=0x12, B=0x13 -> done 8 cycles after accept, a_lt_b=1.
5. Handshake:
   - Hold start=1 through a scan of A=0x01, B=0x00 while changing a/b every cycle -> result unaffected (a_gt_b=1, 8 cycles).
   - start=1 during the DONE cycle with A=0xFF, B=0xFE -> accepted back-to-back; the next done comes 8 cycles later with a_gt_b=1.
6. WIDTH=1 instance: every {a,b,signed_mode} combination -> done 1 cycle after accept; 1 vs 0 gives GT when unsigned and LT when signed; equal operands give EQ.
